// File: rtl/wallace_mul_pipe.sv
// Pipelined WIDTH x WIDTH Wallace-tree multiplier (signed/unsigned per op), 3-stage, valid/ready.
// Optional accumulate mode enabled by defining WALLACE_MUL_ACC_EN.
module wallace_mul_pipe_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ c;
    assign co = (a & b) | (a & c) | (b & c);
endmodule

module wallace_mul_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef WALLACE_MUL_ACC_EN
    input  logic               in_acc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int PW = 2 * WIDTH;

    function automatic int rows_at(int lvl);
        int n = WIDTH;
        for (int i = 0; i < lvl; i++) n = (n / 3) * 2 + (n % 3);
        return n;
    endfunction

    function automatic int num_levels();
        int n = WIDTH;
        int l = 0;
        while (n > 2) begin
            n = (n / 3) * 2 + (n % 3);
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = num_levels();
    localparam int SPLIT  = (LEVELS + 1) / 2;

    // Handshake: a transfer happens on a cycle where valid & ready are both high;
    // a stage loads when its successor is empty or moving, so ready never looks at valid.
    logic v1, v2, v3;
    logic adv2, adv3;
    assign adv3      = ~v3 | out_ready;
    assign adv2      = ~v2 | adv3;
    assign in_ready  = ~v1 | adv2;
    assign out_valid = v3;

    logic [PW-1:0] t   [0:LEVELS][0:WIDTH-1];
    logic [PW-1:0] ins [1:LEVELS][0:WIDTH-1];
    logic [PW-1:0] s1_v [0:WIDTH-1];
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic [PW-1:0] s2_sum, s2_car, acc_term;
    logic [PW-1:0] a_ext;

    assign a_ext = in_signed ? {{WIDTH{in_a[WIDTH-1]}}, in_a} : {{WIDTH{1'b0}}, in_a};

    genvar i, l, k, g, j;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_pp
            if (i == WIDTH - 1) begin : g_top
                // The top row carries negative weight for a two's-complement multiplier.
                assign t[0][i] = in_b[i] ? (in_signed ? -(a_ext << i) : (a_ext << i)) : '0;
            end else begin : g_row
                assign t[0][i] = in_b[i] ? (a_ext << i) : '0;
            end
        end

        for (l = 1; l <= LEVELS; l++) begin : g_lvl
            localparam int N = rows_at(l - 1);
            localparam int G = N / 3;
            localparam int M = rows_at(l);
            for (k = 0; k < WIDTH; k++) begin : g_src
                if (l == SPLIT + 1) begin : g_reg
                    assign ins[l][k] = s1_v[k];
                end else begin : g_comb
                    assign ins[l][k] = t[l-1][k];
                end
            end
            for (g = 0; g < G; g++) begin : g_csa
                logic [PW-1:0] sv, cv;
                for (j = 0; j < PW; j++) begin : g_bit
                    wallace_mul_pipe_fa u_fa (
                        .a (ins[l][3*g][j]),
                        .b (ins[l][3*g+1][j]),
                        .c (ins[l][3*g+2][j]),
                        .s (sv[j]),
                        .co(cv[j])
                    );
                end
                assign t[l][2*g]   = sv;
                assign t[l][2*g+1] = {cv[PW-2:0], 1'b0};
            end
            for (k = 0; k < N % 3; k++) begin : g_pass
                assign t[l][2*G+k] = ins[l][3*G+k];
            end
            for (k = M; k < WIDTH; k++) begin : g_zero
                assign t[l][k] = '0;
            end
        end
    endgenerate

`ifdef WALLACE_MUL_ACC_EN
    logic s1_sgn, s1_acc, s2_sgn, s2_acc, s3_sgn;
    logic [PW-1:0] acc_u, acc_s, acc_fwd;

    // A result retiring this cycle is newer than the stored accumulator, so forward it.
    always_comb begin
        acc_fwd = s2_sgn ? acc_s : acc_u;
        if (v3 && out_ready && (s3_sgn == s2_sgn)) acc_fwd = out_p;
        acc_term = s2_acc ? acc_fwd : '0;
    end
`else
    assign acc_term = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            out_p   <= '0;
            out_tag <= '0;
`ifdef WALLACE_MUL_ACC_EN
            acc_u   <= '0;
            acc_s   <= '0;
`endif
        end else begin
            if (in_ready) begin
                v1 <= in_valid;
                if (in_valid) begin
                    for (int n = 0; n < WIDTH; n++) s1_v[n] <= t[SPLIT][n];
                    s1_tag <= in_tag;
`ifdef WALLACE_MUL_ACC_EN
                    s1_sgn <= in_signed;
                    s1_acc <= in_acc;
`endif
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    s2_sum <= t[LEVELS][0];
                    s2_car <= t[LEVELS][1];
                    s2_tag <= s1_tag;
`ifdef WALLACE_MUL_ACC_EN
                    s2_sgn <= s1_sgn;
                    s2_acc <= s1_acc;
`endif
                end
            end
`ifdef WALLACE_MUL_ACC_EN
            if (v3 && out_ready) begin
                if (s3_sgn) acc_s <= out_p;
                else        acc_u <= out_p;
            end
`endif
            if (adv3) begin
                v3 <= v2;
                if (v2) begin
                    out_p   <= s2_sum + s2_car + acc_term;
                    out_tag <= s2_tag;
`ifdef WALLACE_MUL_ACC_EN
                    s3_sgn  <= s2_sgn;
`endif
                end
            end
        end
    end
endmodule
